// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave register file. Each register is RW, RO (mirrors hw_in) or W1C (hw_in sets, AXI clears).
// Every write applies byte strobes. Per-register write and read pulses go to the user logic.
module axi_lite_regfile_slave #(
    parameter int C_S_AXI_DATA_WIDTH  = 32,
    parameter int C_S_AXI_ADDR_WIDTH  = 6,
    parameter int NUMBER_OF_REGISTERS = 8,
    parameter logic [NUMBER_OF_REGISTERS-1:0] RO_MASK  = '0,
    parameter logic [NUMBER_OF_REGISTERS-1:0] W1C_MASK = '0
) (
    input  logic                                              S_AXI_ACLK,
    input  logic                                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                     S_AXI_AWADDR,
    input  logic [2:0]                                        S_AXI_AWPROT,
    input  logic                                              S_AXI_AWVALID,
    output logic                                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                   S_AXI_WSTRB,
    input  logic                                              S_AXI_WVALID,
    output logic                                              S_AXI_WREADY,
    output logic [1:0]                                        S_AXI_BRESP,
    output logic                                              S_AXI_BVALID,
    input  logic                                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                     S_AXI_ARADDR,
    input  logic [2:0]                                        S_AXI_ARPROT,
    input  logic                                              S_AXI_ARVALID,
    output logic                                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                     S_AXI_RDATA,
    output logic [1:0]                                        S_AXI_RRESP,
    output logic                                              S_AXI_RVALID,
    input  logic                                              S_AXI_RREADY,
    input  logic [NUMBER_OF_REGISTERS*C_S_AXI_DATA_WIDTH-1:0] hw_in,
    output logic [NUMBER_OF_REGISTERS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUMBER_OF_REGISTERS-1:0]                    reg_wr_pulse,
    output logic [NUMBER_OF_REGISTERS-1:0]                    reg_rd_pulse
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int SW       = DW / 8;
    localparam int N        = NUMBER_OF_REGISTERS;
    localparam int ADDR_LSB = (DW == 64) ? 3 : 2;
    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t         r_wstate, w_wstate_next;
    r_state_t         r_rstate, w_rstate_next;
    logic             r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic             w_awready_next, w_wready_next, w_bvalid_next, w_arready_next, w_rvalid_next;
    logic [1:0]       r_bresp, r_rresp;
    logic [DW-1:0]    r_rdata, w_rd_data;
    logic [IDX_W-1:0] r_aw_idx, w_wr_idx, w_rd_idx;
    logic [DW-1:0]    r_wdata, w_wr_data, w_wr_mask;
    logic [SW-1:0]    r_wstrb, w_wr_strb;
    logic [N-1:0]     w_wr_hit, w_rd_hit, w_wr_en;
    logic             w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_err;
    logic             w_unused;

    assign w_aw_hs = S_AXI_AWVALID & r_awready;
    assign w_w_hs  = S_AXI_WVALID & r_wready;
    assign w_ar_hs = S_AXI_ARVALID & r_arready;

    // The channel that completes the pair is taken live; the earlier one comes from its capture register
    assign w_wr_idx  = w_aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB] : r_aw_idx;
    assign w_wr_data = w_w_hs ? S_AXI_WDATA : r_wdata;
    assign w_wr_strb = w_w_hs ? S_AXI_WSTRB : r_wstrb;
    assign w_rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

    assign w_commit = (r_wstate != W_RESP) && (w_wstate_next == W_RESP);
    assign w_wr_err = ~(|w_wr_hit) | (|(w_wr_hit & RO_MASK));
    assign w_wr_en  = {N{w_commit & ~w_wr_err}} & w_wr_hit;

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                        S_AXI_ARADDR[ADDR_LSB-1:0], hw_in};

    // State register, including the registered READY/VALID outputs
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wstate  <= W_IDLE;
            r_rstate  <= R_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_next;
            r_rstate  <= w_rstate_next;
            r_awready <= w_awready_next;
            r_wready  <= w_wready_next;
            r_bvalid  <= w_bvalid_next;
            r_arready <= w_arready_next;
            r_rvalid  <= w_rvalid_next;
        end
    end

    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) w_wstate_next = W_RESP;
                else if (w_aw_hs)      w_wstate_next = W_HAVE_ADDR;
                else if (w_w_hs)       w_wstate_next = W_HAVE_DATA;
            end
            W_HAVE_ADDR: if (w_w_hs)                    w_wstate_next = W_RESP;
            W_HAVE_DATA: if (w_aw_hs)                   w_wstate_next = W_RESP;
            W_RESP:      if (r_bvalid && S_AXI_BREADY)  w_wstate_next = W_IDLE;
            default:                                    w_wstate_next = W_IDLE;
        endcase
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)      w_rstate_next = R_RESP;
            R_RESP:  if (S_AXI_RREADY) w_rstate_next = R_IDLE;
            default:                   w_rstate_next = R_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned with the state
    always_comb begin
        w_awready_next = (w_wstate_next == W_IDLE) || (w_wstate_next == W_HAVE_DATA);
        w_wready_next  = (w_wstate_next == W_IDLE) || (w_wstate_next == W_HAVE_ADDR);
        w_bvalid_next  = (w_wstate_next == W_RESP);
        w_arready_next = (w_rstate_next == R_IDLE);
        w_rvalid_next  = (w_rstate_next == R_RESP);
    end

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_rd_hit[i]) w_rd_data = reg_out[i*DW +: DW];
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_aw_idx     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_bresp      <= 2'b00;
            r_rdata      <= '0;
            r_rresp      <= 2'b00;
            reg_wr_pulse <= '0;
            reg_rd_pulse <= '0;
        end else begin
            if (w_aw_hs) r_aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) r_bresp <= {w_wr_err, 1'b0};
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= {~(|w_rd_hit), 1'b0};
            end
            reg_wr_pulse <= w_wr_en;
            reg_rd_pulse <= {N{w_ar_hs}} & w_rd_hit;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SW; gi++) begin : g_lane
            assign w_wr_mask[gi*8 +: 8] = {8{w_wr_strb[gi]}};
        end

        for (gi = 0; gi < N; gi++) begin : g_reg
            logic [DW-1:0] r_reg;
            assign w_wr_hit[gi]           = (w_wr_idx == IDX_W'(gi));
            assign w_rd_hit[gi]           = (w_rd_idx == IDX_W'(gi));
            assign reg_out[gi*DW +: DW]   = r_reg;

            always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
                if (!S_AXI_ARESETN) begin
                    r_reg <= '0;
                end else if (RO_MASK[gi]) begin
                    r_reg <= hw_in[gi*DW +: DW];
                end else if (W1C_MASK[gi]) begin
                    // OR-ing the hardware set after the clear lets a same-cycle set win
                    r_reg <= (r_reg & ~(w_wr_en[gi] ? (w_wr_data & w_wr_mask) : '0))
                             | hw_in[gi*DW +: DW];
                end else if (w_wr_en[gi]) begin
                    r_reg <= (r_reg & ~w_wr_mask) | (w_wr_data & w_wr_mask);
                end
            end
        end
    endgenerate

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Scoreboard bench for axi_lite_regfile_slave: drivers push expected responses, a negedge monitor checks them.
// Register 6 is read-only and register 3 is write-1-to-clear; everything else is read/write.
module tb_axi_lite_regfile_slave;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int N  = 8;
    localparam logic [N-1:0] RO_M  = 8'h40;
    localparam logic [N-1:0] W1C_M = 8'h08;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [2:0]    awprot = '0, arprot = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;
    logic [N*DW-1:0] hw_in = '0;
    logic [N*DW-1:0] reg_out;
    logic [N-1:0]  wr_pulse, rd_pulse;

    always #5 clk = ~clk;

    axi_lite_regfile_slave #(
        .C_S_AXI_DATA_WIDTH (DW),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUMBER_OF_REGISTERS(N),
        .RO_MASK            (RO_M),
        .W1C_MASK           (W1C_M)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .hw_in        (hw_in),
        .reg_out      (reg_out),
        .reg_wr_pulse (wr_pulse),
        .reg_rd_pulse (rd_pulse)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [7:0]  pulse;
    } exp_t;

    exp_t        b_q[$];
    exp_t        r_q[$];
    exp_t        mon_e;
    logic [31:0] m_regs[N];
    logic [31:0] hw_ro = '0;
    int          errors = 0;
    int          checks = 0;
    logic        prev_b = 1'b0, prev_r = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, expected handshake", name);
    endtask

    // Monitor: each rising BVALID/RVALID must match the oldest expected response
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_b <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            if (bvalid && !prev_b) begin
                if (b_q.size() == 0) fail("b_unexpected");
                else begin
                    mon_e = b_q.pop_front();
                    check("bresp", 32'(bresp), 32'(mon_e.resp));
                    check("wr_pulse", 32'(wr_pulse), 32'(mon_e.pulse));
                    $display("B  resp=%0d wr_pulse=%02h", bresp, wr_pulse);
                end
            end else if (wr_pulse != '0) begin
                check("wr_pulse_idle", 32'(wr_pulse), 32'd0);
            end
            if (rvalid && !prev_r) begin
                if (r_q.size() == 0) fail("r_unexpected");
                else begin
                    mon_e = r_q.pop_front();
                    check("rdata", rdata, mon_e.data);
                    check("rresp", 32'(rresp), 32'(mon_e.resp));
                    check("rd_pulse", 32'(rd_pulse), 32'(mon_e.pulse));
                    $display("R  data=%08h resp=%0d rd_pulse=%02h", rdata, rresp, rd_pulse);
                end
            end else if (rd_pulse != '0) begin
                check("rd_pulse_idle", 32'(rd_pulse), 32'd0);
            end
            prev_b <= bvalid;
            prev_r <= rvalid;
        end
    end

    task automatic push_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int          idx;
        logic [31:0] mask;
        exp_t        e;
        idx  = int'(addr[AW-1:2]);
        mask = '0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask[b*8 +: 8] = 8'hFF;
        e.data = '0;
        if (idx >= N) begin
            e.resp = 2'b10; e.pulse = '0;
        end else if (RO_M[idx]) begin
            e.resp = 2'b10; e.pulse = '0;
        end else begin
            if (W1C_M[idx]) m_regs[idx] = m_regs[idx] & ~(data & mask);
            else            m_regs[idx] = (m_regs[idx] & ~mask) | (data & mask);
            e.resp = 2'b00; e.pulse = 8'(1 << idx);
        end
        b_q.push_back(e);
    endtask

    task automatic drive_aw(input logic [AW-1:0] addr, input int dly);
        int cnt = 0;
        @(negedge clk);
        repeat (dly) @(negedge clk);
        awaddr = addr; awvalid = 1'b1;
        while (!awready && cnt < 64) begin @(negedge clk); cnt++; end
        if (!awready) fail("aw_handshake");
        else @(posedge clk);
        #1 awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        int cnt = 0;
        @(negedge clk);
        repeat (dly) @(negedge clk);
        wdata = data; wstrb = strb; wvalid = 1'b1;
        while (!wready && cnt < 64) begin @(negedge clk); cnt++; end
        if (!wready) fail("w_handshake");
        else @(posedge clk);
        #1 wvalid = 1'b0;
    endtask

    task automatic b_finish(input int dly);
        int cnt = 0;
        repeat (dly) @(negedge clk);
        bready = 1'b1;
        while (!bvalid && cnt < 64) begin @(negedge clk); cnt++; end
        if (!bvalid) fail("b_handshake");
        else @(posedge clk);
        #1 bready = 1'b0;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        push_write(addr, data, strb);
        fork
            drive_aw(addr, aw_dly);
            drive_w(data, strb, w_dly);
        join
        @(negedge clk);
        check("bvalid_latency", 32'(bvalid), 32'd1);
        b_finish(b_dly);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int r_dly, input logic leave_pending);
        int   idx;
        int   cnt = 0;
        exp_t e;
        idx = int'(addr[AW-1:2]);
        if (idx >= N) begin
            e.data = '0; e.resp = 2'b10; e.pulse = '0;
        end else begin
            e.data = m_regs[idx]; e.resp = 2'b00; e.pulse = 8'(1 << idx);
        end
        r_q.push_back(e);
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        while (!arready && cnt < 64) begin @(negedge clk); cnt++; end
        if (!arready) fail("ar_handshake");
        else @(posedge clk);
        #1 arvalid = 1'b0;
        @(negedge clk);
        check("rvalid_latency", 32'(rvalid), 32'd1);
        if (!leave_pending) begin
            repeat (r_dly) begin
                @(negedge clk);
                check("rdata_hold", rdata, e.data);
            end
            rready = 1'b1;
            @(posedge clk);
            #1 rready = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1 ms");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_outputs", {reg_out[31:0], 23'd0, awready, wready, bvalid, arready, rvalid, wr_pulse[0], rd_pulse[0], bresp[1]}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Simultaneous AW/W, then read back
        axi_write(6'h08, 32'hA5A5_1234, 4'hF, 0, 0, 0);
        axi_read(6'h08, 0, 1'b0);
        // Byte strobe on a single lane
        axi_write(6'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(6'h04, 32'h0000_0000, 4'b0010, 1, 0, 1);
        axi_read(6'h04, 2, 1'b0);
        @(negedge clk);
        check("reg_out_1", reg_out[1*DW +: DW], 32'hFFFF_00FF);
        // Out of range and read-only targets
        axi_write(6'h20, 32'h1234_5678, 4'hF, 0, 0, 0);
        axi_read(6'h20, 0, 1'b0);
        axi_write(6'h18, 32'hCAFE_F00D, 4'hF, 0, 1, 0);
        axi_read(6'h18, 0, 1'b0);

        // W1C: hardware set, AXI clear, set beats same-cycle clear
        @(negedge clk) hw_in[3*DW +: DW] = 32'h0000_0011;
        @(negedge clk) hw_in[3*DW +: DW] = 32'h0;
        m_regs[3] = m_regs[3] | 32'h11;
        axi_read(6'h0C, 0, 1'b0);
        axi_write(6'h0C, 32'h0000_0001, 4'hF, 0, 0, 0);
        axi_read(6'h0C, 0, 1'b0);
        @(negedge clk) hw_in[3*DW +: DW] = 32'h0000_0010;
        m_regs[3] = m_regs[3] | 32'h10;
        axi_write(6'h0C, 32'h0000_0010, 4'hF, 0, 0, 0);
        m_regs[3] = m_regs[3] | 32'h10;
        @(negedge clk) hw_in[3*DW +: DW] = 32'h0;
        axi_read(6'h0C, 0, 1'b0);
        check("reg_out_3", reg_out[3*DW +: DW], 32'h0000_0010);

        // W ahead of AW, then BREADY held low for 5 cycles
        push_write(6'h14, 32'h5555_AAAA, 4'hF);
        drive_w(32'h5555_AAAA, 4'hF, 0);
        @(negedge clk);
        check("have_data_wready", 32'(wready), 32'd0);
        check("have_data_awready", 32'(awready), 32'd1);
        drive_aw(6'h14, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bvalid_held", 32'(bvalid), 32'd1);
            check("resp_readys", {30'd0, awready, wready}, 32'd0);
        end
        b_finish(0);
        @(negedge clk);
        check("idle_readys", {30'd0, awready, wready, bvalid}, 32'd6);
        axi_read(6'h14, 0, 1'b0);

        // Randomised traffic, including WSTRB=0 and out-of-range indices
        hw_ro = $urandom;
        @(negedge clk) hw_in[6*DW +: DW] = hw_ro;
        m_regs[6] = hw_ro;
        repeat (2) @(negedge clk);
        for (int t = 0; t < 60; t++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            else
                axi_read(a, $urandom_range(0, 3), 1'b0);
        end

        // Reset with a write parked in W_HAVE_ADDR and a read response pending
        axi_write(6'h00, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        drive_aw(6'h04, 0);
        @(negedge clk);
        check("have_addr_readys", {30'd0, awready, wready}, 32'd1);
        axi_read(6'h00, 0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_readys", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
        check("arst_resps", {28'd0, bresp, rresp}, 32'd0);
        check("arst_rdata", rdata, 32'd0);
        check("arst_reg0", reg_out[0 +: DW], 32'd0);
        check("arst_pulses", {16'd0, wr_pulse, rd_pulse}, 32'd0);
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_regs[6] = hw_ro;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        axi_write(6'h04, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
        axi_read(6'h04, 0, 1'b0);
        axi_read(6'h00, 0, 1'b0);
        axi_read(6'h18, 1, 1'b0);

        repeat (5) @(negedge clk);
        check("b_queue_empty", 32'(b_q.size()), 32'd0);
        check("r_queue_empty", 32'(r_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
